// File: rtl/tag_cmp_victim_sel_if.sv
// rtl/tag_cmp_victim_sel_if.sv - Lookup, tag-memory, result, miss and fill bundle for tag_cmp_victim_sel
// Optional hit/miss counters are present when TAG_CMP_STATS_EN is defined.
interface tag_cmp_victim_sel_if #(
    parameter int TAG_W   = 14,
    parameter int SET_W   = 5,
    parameter int LG_WAYS = 3
);
    localparam int WAYS = 1 << LG_WAYS;

    logic                     req_valid_in;
    logic                     req_ready_out;
    logic [SET_W-1:0]         req_set_in;
    logic [TAG_W-1:0]         req_tag_in;

    logic [SET_W-1:0]         tag_r_addr_out;
    logic [WAYS*TAG_W-1:0]    tag_rdata_in;
    logic [WAYS-1:0]          tag_valid_in;
    logic                     tag_w_en_out;
    logic [SET_W+LG_WAYS-1:0] tag_w_addr_out;
    logic [TAG_W-1:0]         tag_w_data_out;

    logic                     res_valid_out;
    logic                     res_hit_out;
    logic [LG_WAYS-1:0]       res_way_out;
    logic [SET_W-1:0]         res_set_out;
    logic [TAG_W-1:0]         res_tag_out;

    logic                     miss_valid_out;
    logic [SET_W-1:0]         miss_set_out;
    logic [TAG_W-1:0]         miss_tag_out;
    logic [LG_WAYS-1:0]       miss_way_out;
    logic                     fill_done_in;

`ifdef TAG_CMP_STATS_EN
    logic [31:0]              hit_count_out;
    logic [31:0]              miss_count_out;
`endif

    modport slave (
`ifdef TAG_CMP_STATS_EN
        output hit_count_out,
        output miss_count_out,
`endif
        input  req_valid_in,
        output req_ready_out,
        input  req_set_in,
        input  req_tag_in,
        output tag_r_addr_out,
        input  tag_rdata_in,
        input  tag_valid_in,
        output tag_w_en_out,
        output tag_w_addr_out,
        output tag_w_data_out,
        output res_valid_out,
        output res_hit_out,
        output res_way_out,
        output res_set_out,
        output res_tag_out,
        output miss_valid_out,
        output miss_set_out,
        output miss_tag_out,
        output miss_way_out,
        input  fill_done_in
    );

    modport master (
`ifdef TAG_CMP_STATS_EN
        input  hit_count_out,
        input  miss_count_out,
`endif
        output req_valid_in,
        input  req_ready_out,
        output req_set_in,
        output req_tag_in,
        input  tag_r_addr_out,
        output tag_rdata_in,
        output tag_valid_in,
        input  tag_w_en_out,
        input  tag_w_addr_out,
        input  tag_w_data_out,
        input  res_valid_out,
        input  res_hit_out,
        input  res_way_out,
        input  res_set_out,
        input  res_tag_out,
        input  miss_valid_out,
        input  miss_set_out,
        input  miss_tag_out,
        input  miss_way_out,
        output fill_done_in
    );
endinterface

// File: rtl/tag_cmp_victim_sel.sv
// rtl/tag_cmp_victim_sel.sv - Tag compare, invalid-first/tree-PLRU victim select and miss fill write-back
// Define TAG_CMP_STATS_EN to add saturating hit/miss counters.
module tag_cmp_victim_sel #(
    parameter int TAG_W   = 14,
    parameter int SET_W   = 5,
    parameter int LG_WAYS = 3
) (
    input  logic               clk,
    input  logic               reset,
    tag_cmp_victim_sel_if.slave bus
);
    localparam int WAYS = 1 << LG_WAYS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                  state_q, state_d;

    logic                    s1_valid_q, s1_valid_d;
    logic [SET_W-1:0]        s1_set_q, s1_set_d;
    logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;

    logic                    res_valid_q, res_valid_d;
    logic                    res_hit_q, res_hit_d;
    logic [LG_WAYS-1:0]      res_way_q, res_way_d;
    logic [SET_W-1:0]        res_set_q, res_set_d;
    logic [TAG_W-1:0]        res_tag_q, res_tag_d;

    logic [SET_W-1:0]        miss_set_q, miss_set_d;
    logic [TAG_W-1:0]        miss_tag_q, miss_tag_d;
    logic [LG_WAYS-1:0]      miss_way_q, miss_way_d;

    logic [(1<<SET_W)-1:0][6:0] plru_q, plru_d;

    logic                    s1_hit;
    logic [LG_WAYS-1:0]      s1_hit_way;
    logic                    s1_any_inv;
    logic [LG_WAYS-1:0]      s1_inv_way;
    logic [LG_WAYS-1:0]      s1_victim;
    logic                    req_ready;

    // Tree walk: b0 picks the half, b1/b2 the quarter, b3..b6 the way; a 0 bit points low.
    function automatic logic [2:0] plru_victim(input logic [6:0] b);
        logic       h;
        logic       m;
        logic [2:0] leaf;
        h    = b[0];
        m    = h ? b[2] : b[1];
        leaf = 3'd3 + {1'b0, h, m};
        return {h, m, b[leaf]};
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
        logic [6:0] r;
        logic [2:0] mid;
        logic [2:0] leaf;
        r       = b;
        mid     = 3'd1 + {2'b00, w[2]};
        leaf    = 3'd3 + {1'b0, w[2], w[1]};
        r[0]    = ~w[2];
        r[mid]  = ~w[1];
        r[leaf] = ~w[0];
        return r;
    endfunction

    // Scanning from the top down leaves the lowest matching / lowest invalid way selected.
    always_comb begin
        s1_hit     = 1'b0;
        s1_hit_way = '0;
        s1_any_inv = 1'b0;
        s1_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.tag_valid_in[i] && (bus.tag_rdata_in[i*TAG_W +: TAG_W] == s1_tag_q)) begin
                s1_hit     = 1'b1;
                s1_hit_way = LG_WAYS'(i);
            end
            if (!bus.tag_valid_in[i]) begin
                s1_any_inv = 1'b1;
                s1_inv_way = LG_WAYS'(i);
            end
        end
    end

    assign s1_victim = s1_any_inv ? s1_inv_way : LG_WAYS'(plru_victim(plru_q[s1_set_q]));
    assign req_ready = (state_q == ST_IDLE) && !(s1_valid_q && !s1_hit);

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = 1'b0;
        s1_set_d    = s1_set_q;
        s1_tag_d    = s1_tag_q;
        res_valid_d = s1_valid_q;
        res_hit_d   = res_hit_q;
        res_way_d   = res_way_q;
        res_set_d   = res_set_q;
        res_tag_d   = res_tag_q;
        miss_set_d  = miss_set_q;
        miss_tag_d  = miss_tag_q;
        miss_way_d  = miss_way_q;
        plru_d      = plru_q;

        if (bus.req_valid_in && req_ready) begin
            s1_valid_d = 1'b1;
            s1_set_d   = bus.req_set_in;
            s1_tag_d   = bus.req_tag_in;
        end

        if (s1_valid_q) begin
            res_hit_d = s1_hit;
            res_way_d = s1_hit ? s1_hit_way : s1_victim;
            res_set_d = s1_set_q;
            res_tag_d = s1_tag_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (s1_valid_q) begin
                    if (s1_hit) begin
                        plru_d[s1_set_q] = plru_touch(plru_q[s1_set_q], 3'(s1_hit_way));
                    end else begin
                        state_d    = ST_MISS;
                        miss_set_d = s1_set_q;
                        miss_tag_d = s1_tag_q;
                        miss_way_d = s1_victim;
                    end
                end
            end
            ST_MISS: begin
                if (bus.fill_done_in) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The filled way becomes most recently used as its tag is written back.
                plru_d[miss_set_q] = plru_touch(plru_q[miss_set_q], 3'(miss_way_q));
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_set_q    <= '0;
            s1_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_way_q   <= '0;
            res_set_q   <= '0;
            res_tag_q   <= '0;
            miss_set_q  <= '0;
            miss_tag_q  <= '0;
            miss_way_q  <= '0;
            plru_q      <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_set_q    <= s1_set_d;
            s1_tag_q    <= s1_tag_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_way_q   <= res_way_d;
            res_set_q   <= res_set_d;
            res_tag_q   <= res_tag_d;
            miss_set_q  <= miss_set_d;
            miss_tag_q  <= miss_tag_d;
            miss_way_q  <= miss_way_d;
            plru_q      <= plru_d;
        end
    end

    assign bus.req_ready_out  = req_ready;
    assign bus.tag_r_addr_out = bus.req_set_in;
    assign bus.tag_w_en_out   = (state_q == ST_WRITE);
    assign bus.tag_w_addr_out = {miss_set_q, miss_way_q};
    assign bus.tag_w_data_out = miss_tag_q;
    assign bus.res_valid_out  = res_valid_q;
    assign bus.res_hit_out    = res_hit_q;
    assign bus.res_way_out    = res_way_q;
    assign bus.res_set_out    = res_set_q;
    assign bus.res_tag_out    = res_tag_q;
    assign bus.miss_valid_out = (state_q == ST_MISS);
    assign bus.miss_set_out   = miss_set_q;
    assign bus.miss_tag_out   = miss_tag_q;
    assign bus.miss_way_out   = miss_way_q;

`ifdef TAG_CMP_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (res_valid_q && res_hit_q && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (res_valid_q && !res_hit_q && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count_out  = hit_count_q;
    assign bus.miss_count_out = miss_count_q;
`endif
endmodule
